// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised RS-232 receiver with 3-sample majority voting,
// parity/frame/break detection and a valid/ready holding register.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16,
  parameter int IDLE_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic [15:0]          baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  output logic                 rx_busy,
  output logic                 rx_idle
);
  localparam int PW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);
  localparam int M       = OVERSAMPLE / 2;
  localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int GW      = $clog2(GAP_MAX + 1);

  localparam logic [PW-1:0] P_LO  = PW'(M - 1);
  localparam logic [PW-1:0] P_MID = PW'(M);
  localparam logic [PW-1:0] P_DEC = PW'(M + 1);
  localparam logic [PW-1:0] P_END = PW'(OVERSAMPLE - 1);
  localparam logic          ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HIGH
  } state_t;

  state_t               state, stateNext;
  logic [15:0]          tickCnt;
  logic [1:0]           sync;
  logic [PW-1:0]        phase;
  logic [BW-1:0]        bitCnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parErr;
  logic                 parBit;
  logic [GW-1:0]        gapCnt;
  logic                 tick;
  logic                 syncBit;
  logic                 vote;
  logic                 decide;
  logic                 wrap;
  logic                 frameDone;

  assign tick    = (tickCnt == baud_div);
  assign syncBit = sync[1];
  assign vote    = (samp[0] & samp[1]) |
                   (samp[0] & syncBit) |
                   (samp[1] & syncBit);
  assign decide  = tick && (phase == P_DEC);
  assign wrap    = tick && (phase == P_END);
  assign rx_busy = (state != IDLE);
  assign rx_idle = (gapCnt == GW'(GAP_MAX));

  always_comb begin
    stateNext = state;
    frameDone = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && !syncBit) stateNext = START;
      end
      START: begin
        if (decide && vote) stateNext = IDLE;
        else if (wrap) stateNext = DATA;
      end
      DATA: begin
        if (wrap && bitCnt == BW'(DATA_BITS))
          stateNext = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (wrap) stateNext = STOP;
      end
      STOP: begin
        if (decide) begin
          frameDone = 1'b1;
          stateNext = vote ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (tick && syncBit) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tickCnt  <= '0;
      sync     <= 2'b11;
      phase    <= '0;
      bitCnt   <= '0;
      samp     <= '0;
      shiftReg <= '0;
      parErr   <= 1'b0;
      parBit   <= 1'b0;
      gapCnt   <= '0;
    end else begin
      state   <= stateNext;
      sync    <= {sync[0], rxd};
      tickCnt <= tick ? '0 : tickCnt + 16'd1;
      // phase sits at 0 in IDLE so a start edge begins a fresh bit
      if (tick) begin
        phase <= (state == IDLE) ? '0 : phase + PW'(1);
        if (phase == P_LO)  samp[0] <= syncBit;
        if (phase == P_MID) samp[1] <= syncBit;
      end
      if (state == IDLE) bitCnt <= '0;
      if (decide && state == DATA) begin
        shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
        bitCnt   <= bitCnt + BW'(1);
      end
      if (decide && state == PAR) begin
        parBit <= vote;
        parErr <= vote ^ (^shiftReg) ^ ODD;
      end
      if (state != IDLE) gapCnt <= '0;
      else if (tick && !rx_idle) gapCnt <= gapCnt + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (frameDone && (!rx_valid || rx_ready)) begin
        rx_data       <= shiftReg;
        rx_valid      <= 1'b1;
        rx_parity_err <= (PARITY != 0) && parErr;
        rx_frame_err  <= !vote;
        rx_break      <= (shiftReg == '0) && !vote &&
                         (PARITY == 0 || !parBit);
      end else begin
        if (frameDone) rx_overrun <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives three receivers (no/even/odd parity) with
// directed and random frames, checked against a frame-level model.
module tb_uart_rx_param;
  localparam int OS  = 16;
  localparam int DB  = 8;
  localparam int M   = OS / 2;
  localparam int BD  = 3;
  localparam int CPB = (BD + 1) * OS;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       br;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baudDiv = 16'(BD);
  logic [2:0]  rxdL = 3'b111;
  logic [2:0]  rxReady = 3'b111;
  logic [7:0]  rxData [3];
  logic [2:0]  rxValid, parErr, frameErr, brk;
  logic [2:0]  overrun, busy, idle;

  for (genvar g = 0; g < 3; g++) begin : gDut
    uart_rx_param #(
      .DATA_BITS(DB), .PARITY(g),
      .OVERSAMPLE(OS), .IDLE_BITS(2)
    ) dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxdL[g]),
      .baud_div(baudDiv), .rx_data(rxData[g]),
      .rx_valid(rxValid[g]), .rx_ready(rxReady[g]),
      .rx_parity_err(parErr[g]),
      .rx_frame_err(frameErr[g]),
      .rx_break(brk[g]), .rx_overrun(overrun[g]),
      .rx_busy(busy[g]), .rx_idle(idle[g])
    );
  end

  always #5 clk = ~clk;

  int   nChecks = 0;
  int   nFails = 0;
  int   cur = 0;
  int   edgeCnt = 0;
  int   riseEdge = -1;
  int   ovCycles = 0;
  int   startE = 0;
  logic prevV = 1'b0;
  exp_t expQ[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int g, input logic [7:0] d,
                                 input logic pb, input logic sb);
    exp_t e;
    e.d  = d;
    e.fe = !sb;
    e.pe = (g == 1) ? ((^d) != pb) :
           (g == 2) ? ((^d) == pb) : 1'b0;
    e.br = (d == 8'h00) && !sb && (g == 0 || !pb);
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) edgeCnt <= 0;
    else edgeCnt <= edgeCnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rxValid[cur] && !prevV) riseEdge <= edgeCnt;
      if (overrun[cur]) ovCycles <= ovCycles + 1;
      if (rxValid[cur] && rxReady[cur]) begin
        exp_t e;
        chk("word expected", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          chk("rx_data", rxData[cur], e.d);
          chk("parity_err", parErr[cur], e.pe);
          chk("frame_err", frameErr[cur], e.fe);
          chk("break", brk[cur], e.br);
        end
      end
      prevV <= rxValid[cur];
    end else begin
      prevV <= 1'b0;
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [7:0] d,
                      input logic pb, input logic sb,
                      input int lowExtra, input int gap,
                      input int spike, input bit push);
    logic seq [12];
    int   nb;
    nb = 0;
    seq[nb++] = 1'b0;
    for (int i = 0; i < DB; i++) seq[nb++] = d[i];
    if (g != 0) seq[nb++] = pb;
    seq[nb++] = sb;
    if (push) expQ.push_back(model(g, d, pb, sb));
    startE = edgeCnt;
    for (int i = 0; i < nb; i++) begin
      rxdL[g] = seq[i];
      if (i == spike) begin
        waitClk(36);
        rxdL[g] = ~seq[i];
        waitClk(4);
        rxdL[g] = seq[i];
        waitClk(CPB - 40);
      end else begin
        waitClk(CPB);
      end
    end
    if (lowExtra > 0) begin
      rxdL[g] = 1'b0;
      waitClk(lowExtra * CPB);
    end
    rxdL[g] = 1'b1;
    waitClk(gap * CPB);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 4 * CPB) begin
      waitClk(1);
      n++;
    end
    chk("queue drained", expQ.size(), 0);
  endtask

  initial begin
    int   es;
    int   ed;
    bit   sawBusy;
    logic [7:0] d;
    logic pb, sb;
    int   gap;

    waitClk(3);
    chk("rst data", rxData[0], 0);
    chk("rst valid", rxValid, 0);
    chk("rst flags", {parErr, frameErr, brk}, 0);
    chk("rst ovr/busy/idle", {overrun, busy, idle}, 0);
    rst_n = 1'b1;
    while (edgeCnt < 127) waitClk(1);
    chk("idle before limit", idle[0], 0);
    waitClk(1);
    chk("idle at limit", idle[0], 1);

    // 8N1 frame with exact completion latency
    cur = 0;
    riseEdge = -1;
    send(0, 8'hA5, 1'b0, 1'b1, 0, 2, -1, 1);
    drain();
    ed = ((startE + 3 + 3) / 4) * 4;
    es = ed + ((1 + DB) * OS + M + 2) * (BD + 1);
    chk("valid latency", riseEdge, es);

    // even then odd parity
    cur = 1;
    send(1, 8'h03, 1'b1, 1'b1, 0, 2, -1, 1);
    send(1, 8'h03, 1'b0, 1'b1, 0, 2, -1, 1);
    drain();
    cur = 2;
    send(2, 8'h03, 1'b1, 1'b1, 0, 2, -1, 1);
    send(2, 8'h03, 1'b0, 1'b1, 0, 2, -1, 1);
    drain();

    // framing error with held-low line, then a clean frame
    cur = 0;
    send(0, 8'h55, 1'b0, 1'b0, 3, 2, -1, 1);
    send(0, 8'h3C, 1'b0, 1'b1, 0, 2, -1, 1);
    drain();

    // break: 20 bit-times low
    send(0, 8'h00, 1'b0, 1'b0, 10, 0, -1, 1);
    chk("break busy held", busy[0], 1);
    waitClk(12);
    chk("break busy clear", busy[0], 0);
    drain();
    waitClk(2 * CPB);

    // one-tick glitch is a false start
    rxdL[0] = 1'b0;
    waitClk(4);
    rxdL[0] = 1'b1;
    sawBusy = 1'b0;
    for (int i = 0; i < 52; i++) begin
      waitClk(1);
      if (busy[0]) sawBusy = 1'b1;
    end
    chk("glitch busy seen", sawBusy, 1);
    chk("glitch busy clear", busy[0], 0);
    send(0, 8'hF0, 1'b0, 1'b1, 0, 2, 2, 1);
    drain();

    // random frames on each parity flavour
    for (int g = 0; g < 3; g++) begin
      cur = g;
      waitClk(CPB);
      for (int k = 0; k < 5; k++) begin
        d   = 8'($urandom);
        pb  = 1'($urandom);
        sb  = ($urandom_range(3) != 0);
        gap = sb ? $urandom_range(2) : 1 + $urandom_range(1);
        send(g, d, pb, sb, 0, gap, -1, 1);
      end
      rxdL[g] = 1'b1;
      waitClk(CPB);
      drain();
    end

    // overrun with consumer stalled
    cur = 0;
    rxReady[0] = 1'b0;
    ovCycles = 0;
    send(0, 8'h11, 1'b0, 1'b1, 0, 2, -1, 1);
    send(0, 8'h22, 1'b0, 1'b1, 0, 2, -1, 0);
    chk("ovr held data", rxData[0], 8'h11);
    chk("ovr held valid", rxValid[0], 1);
    chk("ovr pulse clks", ovCycles, 1);
    rxReady[0] = 1'b1;
    waitClk(1);
    chk("valid drop", rxValid[0], 0);
    chk("ovr drained", expQ.size(), 0);

    // reset mid-frame
    rxdL[0] = 1'b0;
    waitClk(CPB);
    rxdL[0] = 1'b1;
    waitClk(2 * CPB);
    rxdL[0] = 1'b0;
    waitClk(CPB / 2);
    chk("busy mid-frame", busy[0], 1);
    rst_n = 1'b0;
    waitClk(2);
    chk("mid rst data", rxData[0], 0);
    chk("mid rst valid", rxValid, 0);
    chk("mid rst flags", {parErr, frameErr, brk}, 0);
    chk("mid rst ovr/busy/idle", {overrun, busy, idle}, 0);
    rxdL[0] = 1'b1;
    rst_n = 1'b1;
    waitClk(3 * CPB);
    send(0, 8'h7E, 1'b0, 1'b1, 0, 2, -1, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
